// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types, defaults and helpers for the button event controller
// Purpose: debounce state encoding, default timing constants and the event code width helper.
// Ports: none (package).
package btn_pkg;

  typedef enum logic [1:0] {
    LO     = 2'd0,
    CHK_HI = 2'd1,
    HI     = 2'd2,
    CHK_LO = 2'd3
  } deb_state_e;

  localparam int STABLE_CYC_DEF = 1000000;
  localparam int REPEAT_DLY_DEF = 30000000;
  localparam int REPEAT_PER_DEF = 10000000;

  // A single channel still needs a 1-bit code field.
  function automatic int code_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/btn_event_ctrl_if.sv
// rtl/btn_event_ctrl_if.sv - valid/ready event port between button controller and CPU bus
// Purpose: carries one queued press event (channel index) per handshake.
// Ports (signals):
//   evt_valid_o  event available (driven by master)
//   evt_code_o   channel index of the presented event (driven by master)
//   evt_ready_i  consumer accepts when valid && ready (driven by slave)
interface btn_event_ctrl_if #(
  parameter int CODE_W = 3
);
  logic              evt_valid_o;
  logic [CODE_W-1:0] evt_code_o;
  logic              evt_ready_i;

  modport master (output evt_valid_o, output evt_code_o, input evt_ready_i);
  modport slave  (input evt_valid_o, input evt_code_o, output evt_ready_i);
endinterface

// File: rtl/btn_chan_debounce.sv
// rtl/btn_chan_debounce.sv - one button channel: synchroniser, debounce FSM, optional auto-repeat
// Purpose: turns a raw asynchronous button into a debounced level plus press/release pulses.
// Optional feature: BTN_AUTOREPEAT_EN adds a repeat timer that emits extra press pulses while held.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   btn_i      raw button input, 1 = pressed
//   level_o    debounced level
//   press_o    one-cycle pulse on debounced 0->1 (and on each auto-repeat)
//   release_o  one-cycle pulse on debounced 1->0
module btn_chan_debounce
  import btn_pkg::*;
#(
  parameter int STABLE_CYC = STABLE_CYC_DEF,
  parameter int CNT_W      = $clog2(STABLE_CYC + 1)
`ifdef BTN_AUTOREPEAT_EN
  , parameter int REPEAT_DLY = REPEAT_DLY_DEF,
  parameter int REPEAT_PER = REPEAT_PER_DEF
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [1:0]       S_LO     = LO;
  localparam logic [1:0]       S_CHK_HI = CHK_HI;
  localparam logic [1:0]       S_HI     = HI;
  localparam logic [1:0]       S_CHK_LO = CHK_LO;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);

  logic             sync1_q, sync2_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DLY - 1);
  localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PER - 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             arm_q, arm_d;  // first repeat already issued; now on the short period
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      S_LO: begin
        if (sync2_q) begin
          state_d = S_CHK_HI;
          cnt_d   = CNT_W'(1);
        end
      end
      S_CHK_HI: begin
        if (!sync2_q) begin
          state_d = S_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HI;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HI: begin
        if (!sync2_q) begin
          state_d = S_CHK_LO;
          cnt_d   = CNT_W'(1);
        end
      end
      S_CHK_LO: begin
        if (sync2_q) begin
          state_d = S_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_LO;
          level_d   = 1'b0;
          release_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_LO;
        cnt_d   = '0;
      end
    endcase

`ifdef BTN_AUTOREPEAT_EN
    rpt_d = rpt_q;
    arm_d = arm_q;
    // Counts only while HI; CHK_LO freezes it so a release bounce does not restart the delay.
    if (state_q == S_HI) begin
      if (rpt_q == (arm_q ? PER_LAST : DLY_LAST)) begin
        press_d = 1'b1;
        rpt_d   = '0;
        arm_d   = 1'b1;
      end else begin
        rpt_d = rpt_q + RPT_W'(1);
      end
    end else if (state_q != S_CHK_LO) begin
      rpt_d = '0;
      arm_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= S_LO;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt_q     <= '0;
      arm_q     <= 1'b0;
`endif
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef BTN_AUTOREPEAT_EN
      rpt_q     <= rpt_d;
      arm_q     <= arm_d;
`endif
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_event_ctrl.sv
// rtl/btn_event_ctrl.sv - CH-channel debounced push-button front end with queued press events
// Purpose: debounces each button, latches presses in a per-channel pending register and
// drains them lowest-index first through a valid/ready event port.
// Optional feature: BTN_AUTOREPEAT_EN (auto-repeat presses while a button is held).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   btn_i           raw button inputs, 1 = pressed
//   btn_level_o     debounced levels
//   btn_press_o     one-cycle press pulses
//   btn_release_o   one-cycle release pulses
//   evt             event port (master): evt_valid_o, evt_code_o, evt_ready_i
//   evt_drop_o      one-cycle pulse when a press is lost to an already-pending channel
module btn_event_ctrl
  import btn_pkg::*;
#(
  parameter int CH         = 5,
  parameter int STABLE_CYC = STABLE_CYC_DEF,
  parameter int CNT_W      = $clog2(STABLE_CYC + 1)
`ifdef BTN_AUTOREPEAT_EN
  , parameter int REPEAT_DLY = REPEAT_DLY_DEF,
  parameter int REPEAT_PER = REPEAT_PER_DEF
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CH-1:0]           btn_i,
  output logic [CH-1:0]           btn_level_o,
  output logic [CH-1:0]           btn_press_o,
  output logic [CH-1:0]           btn_release_o,
  btn_event_ctrl_if.master        evt,
  output logic                    evt_drop_o
);

  localparam int CODE_W = code_w(CH);

  for (genvar g = 0; g < CH; g++) begin : g_chan
    btn_chan_debounce #(
      .STABLE_CYC (STABLE_CYC),
      .CNT_W      (CNT_W)
`ifdef BTN_AUTOREPEAT_EN
      , .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_PER (REPEAT_PER)
`endif
    ) u_deb (
      .clk       (clk),
      .rst       (rst),
      .btn_i     (btn_i[g]),
      .level_o   (btn_level_o[g]),
      .press_o   (btn_press_o[g]),
      .release_o (btn_release_o[g])
    );
  end

  logic [CH-1:0]     pend_q, pend_d;
  logic              valid_q, valid_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              drop_q, drop_d;

  logic [CH-1:0]     avail;
  logic [CH-1:0]     take;
  logic [CODE_W-1:0] code_sel;
  logic              found;
  logic              load;

  always_comb begin
    // A press arriving this cycle may load straight into an empty event register.
    avail    = pend_q | btn_press_o;
    load     = !valid_q || evt.evt_ready_i;
    found    = 1'b0;
    code_sel = '0;
    take     = '0;
    for (int i = 0; i < CH; i++) begin
      if (avail[i] && !found) begin
        found    = 1'b1;
        code_sel = CODE_W'(i);
        take[i]  = load;
      end
    end

    valid_d = valid_q;
    code_d  = code_q;
    if (load) begin
      valid_d = found;
      if (found) code_d = code_sel;
    end

    // The taken event comes from pend_q when it was set; only then does a new press stay pending.
    pend_d = (pend_q & ~take) | (btn_press_o & ~(take & ~pend_q));
    drop_d = |(btn_press_o & pend_q & ~take);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      drop_q  <= drop_d;
    end
  end

  assign evt.evt_valid_o = valid_q;
  assign evt.evt_code_o  = code_q;
  assign evt_drop_o      = drop_q;

endmodule
